// File: rtl/regfile_dump_reader.sv
// Walks a wrapping range of register-file addresses and streams each value on a valid/ready port.
// Optional trailing XOR checksum beat when REGFILE_DUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]  rf_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StFetch, StSend, StCksum, StFin} state_e;

  localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   OneW     = (ADDR_W + 1)'(1);

  state_e          state_q;
  logic [ADDR_W:0] remaining_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] cksum_q;
`endif

  // rf_rd_addr doubles as the current walk address; it only moves on entry to StFetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      rf_rd_addr  <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy        <= 1'b1;
            rf_rd_addr  <= ({1'b0, start_addr} >= NumRegsW) ? '0 : start_addr;
            remaining_q <= (count > NumRegsW) ? NumRegsW : count;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            cksum_q     <= '0;
`endif
            if (count == '0) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          out_data  <= rf_rd_data;
          out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          cksum_q   <= cksum_q ^ rf_rd_data;
`else
          out_last  <= (remaining_q == OneW);
`endif
          state_q   <= StSend;
        end
        StSend: begin
          if (out_ready) begin
            remaining_q <= remaining_q - OneW;
            if (remaining_q == OneW) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
              // Checksum beat follows immediately; cksum_q already covers the final register.
              out_data <= cksum_q;
              out_last <= 1'b1;
              state_q  <= StCksum;
`else
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              state_q   <= StFin;
`endif
            end else begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              rf_rd_addr <= (rf_rd_addr == LastAddr) ? '0 : rf_rd_addr + 1'b1;
              state_q    <= StFetch;
            end
          end
        end
        StCksum: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state_q   <= StFin;
          end
        end
        StFin: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table-driven dumps, reset abort, then randomized dumps
// against a queue-based beat model (honours REGFILE_DUMP_CHECKSUM_EN).
module tb_regfile_dump_reader;
  localparam int unsigned W  = 32;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, out_valid, out_ready, out_last, busy, done;
  logic [AW-1:0] start_addr, rf_rd_addr;
  logic [AW:0]   count;
  logic [W-1:0]  rf_rd_data, out_data;
  logic [W-1:0]  rf [NR];

  int total = 0;
  int bad   = 0;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CksBeat = 1;
`else
  localparam int CksBeat = 0;
`endif

  always #5 clk = ~clk;

  assign rf_rd_data = rf[rf_rd_addr[2:0]];

  regfile_dump_reader #(.WIDTH(W), .NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .count     (count),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [3:0] sa;
    logic [4:0] cnt;
    int         mode;       // 0 ready high, 1 stall one beat, 2 random ready
    int         stall_beat;
    int         stall_len;
    bit         poke;       // pulse start mid-dump
    int         exp_first;
    int         exp_n;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_dump(input logic [3:0] sa, input logic [4:0] cnt, input int mode,
                          input int stall_beat, input int stall_len, input bit poke,
                          input int first, input int n, input string tag);
    logic [W-1:0] exp_q[$];
    int           addr_q[$];
    logic [W-1:0] x;
    int           cyc, idx, stall, done_cyc;
    x = '0;
    for (int i = 0; i < n; i++) begin
      int a;
      a = (first + i) % NR;
      addr_q.push_back(a);
      exp_q.push_back(rf[a]);
      x ^= rf[a];
    end
    if (CksBeat == 1 && n > 0) begin
      exp_q.push_back(x);
      addr_q.push_back(-1);
    end

    start_addr = sa;
    count      = cnt;
    start      = 1'b1;
    out_ready  = 1'b1;
    step();
    start    = 1'b0;
    cyc      = 1;
    idx      = 0;
    stall    = 0;
    done_cyc = -1;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
    while (done_cyc < 0 && cyc < 200) begin
      case (mode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid && idx == stall_beat && stall < stall_len) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (poke) begin
        start      = (cyc == 3);
        start_addr = AW'($urandom_range(0, 15));
        count      = 5'($urandom_range(0, 16));
      end
      if (done) done_cyc = cyc;
      if (out_valid) begin
        if (idx < exp_q.size()) begin
          check({tag, " data"}, 64'(out_data), 64'(exp_q[idx]));
          check({tag, " last"}, 64'(out_last), 64'(idx == exp_q.size() - 1));
          if (addr_q[idx] >= 0) check({tag, " rd_addr"}, 64'(rf_rd_addr), 64'(addr_q[idx]));
        end else begin
          check({tag, " extra beat"}, 64'(idx), 64'(exp_q.size()));
        end
        if (out_ready) idx++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    if (done_cyc < 0) check({tag, " done timeout"}, 64'd0, 64'd1);
    check({tag, " beat count"}, 64'(idx), 64'(exp_q.size()));
    if (mode == 0)
      check({tag, " done latency"}, 64'(done_cyc), 64'((n == 0) ? 1 : 2 * n + 1 + CksBeat));
    check({tag, " busy after done"}, 64'(busy), 64'd0);
    check({tag, " done one cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    int hs, guard;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + W'(i);
    #12;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    check("reset out_last", 64'(out_last), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset rd_addr", 64'(rf_rd_addr), 64'd0);
    rst_n = 1'b1;
    step();

    vecs[0] = '{4'd0,  5'd8,  0, 0, 0, 1'b0, 0, 8};
    vecs[1] = '{4'd6,  5'd4,  0, 0, 0, 1'b0, 6, 4};
    vecs[2] = '{4'd0,  5'd8,  1, 1, 5, 1'b0, 0, 8};
    vecs[3] = '{4'd0,  5'd0,  0, 0, 0, 1'b0, 0, 0};
    vecs[4] = '{4'd2,  5'd12, 0, 0, 0, 1'b0, 2, 8};
    vecs[5] = '{4'd9,  5'd3,  0, 0, 0, 1'b0, 0, 3};
    vecs[6] = '{4'd1,  5'd6,  0, 0, 0, 1'b1, 1, 6};
    vecs[7] = '{4'd7,  5'd1,  0, 0, 0, 1'b0, 7, 1};
    vecs[8] = '{4'd15, 5'd16, 2, 0, 0, 1'b0, 0, 8};
    for (int v = 0; v < 9; v++) begin
      run_dump(vecs[v].sa, vecs[v].cnt, vecs[v].mode, vecs[v].stall_beat, vecs[v].stall_len,
               vecs[v].poke, vecs[v].exp_first, vecs[v].exp_n, $sformatf("vec%0d", v));
      step();
    end

    // Checksum-friendly pattern: XOR of 1,2,4,8 is 0xF.
    rf[0] = 32'h1; rf[1] = 32'h2; rf[2] = 32'h4; rf[3] = 32'h8;
    run_dump(4'd0, 5'd4, 0, 0, 0, 1'b0, 0, 4, "cksum");
    step();

    // Reset mid-dump during beat 4.
    for (int i = 0; i < NR; i++) rf[i] = 32'h1000_0000 + W'(i);
    start_addr = '0;
    count      = 5'd8;
    out_ready  = 1'b1;
    start      = 1'b1;
    step();
    start = 1'b0;
    hs    = 0;
    guard = 0;
    while (hs < 3 && guard < 50) begin
      if (out_valid && out_ready) hs++;
      step();
      guard++;
    end
    step();
    check("abort precondition valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort rd_addr", 64'(rf_rd_addr), 64'd0);
    step();
    check("abort no done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post-abort idle done", 64'(done), 64'd0);
    run_dump(4'd3, 5'd4, 0, 0, 0, 1'b0, 3, 4, "after abort");
    step();

    for (int r = 0; r < 30; r++) begin
      logic [3:0] sa;
      logic [4:0] cnt;
      int         first, n;
      for (int i = 0; i < NR; i++) rf[i] = $urandom;
      sa    = 4'($urandom_range(0, 15));
      cnt   = 5'($urandom_range(0, 16));
      first = (sa >= NR) ? 0 : int'(sa);
      n     = (cnt > NR) ? NR : int'(cnt);
      run_dump(sa, cnt, ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 0, 1'($urandom_range(0, 1)),
               first, n, $sformatf("rand%0d", r));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
